// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the serial-in/parallel-out receive controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sipo_rx_pkg;

    // Default number of data bits per frame.
    localparam int WIDTH_DEF = 8;

    // Frame sequencer states; PARITY is only reachable when RX_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    // Parity sense used by the receiver.
    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_e;

    localparam parity_e RX_PARITY_TYPE = PAR_EVEN;

    // Returns 1 when the received parity bit disagrees with the data bits.
    // data_xor is the XOR reduction of the data word.
    function automatic logic parity_bad(input logic par_bit, input logic data_xor);
        return par_bit ^ data_xor ^ (RX_PARITY_TYPE == PAR_ODD);
    endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// LSB-first shift register: new bits enter at the MSB and move toward bit 0.
// Latency: one clock per enabled shift.
// Backpressure: none; holds its contents whenever shift_en is low.
module sipo_shift_en
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Shift one serial bit in at the top on each enabled clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (shift_en) begin
            q_q <= {din, q_q[WIDTH-1:1]};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial frame receiver: start + WIDTH data (+ parity with RX_PARITY_EN) + stop, committed to a valid/ready holding register.
// Latency: dout_valid rises 1 clk after the stop-bit sample; error pulses appear on the same clock.
// Backpressure: none upstream; a commit while dout is held unconsumed overwrites dout and pulses overrun.
module sipo_rx_ctrl
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
`ifdef RX_PARITY_EN
    ,
    output logic             par_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

`ifdef RX_PARITY_EN
    localparam state_e DATA_NEXT = PARITY;
`else
    localparam state_e DATA_NEXT = STOP;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg;
    logic             shift_en;
    logic             stop_smp;
    logic             par_ok;
    logic             commit;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q;
    logic             ovr_q;
    logic             busy_q;

    // Data bits are captured only while in DATA on a bit strobe.
    assign shift_en = bit_en && (state_q == DATA);

    sipo_shift_en #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst),
        .shift_en (shift_en),
        .din      (sin),
        .q        (shreg)
    );

    // Next-state and bit counter; nothing moves without a bit strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    // Counter saturates at the last data bit rather than wrapping.
                    if (cnt_q == CNT_MAX) begin
                        state_d = DATA_NEXT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    state_d = STOP;
                end
`endif
                STOP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state and bit counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The stop bit is being sampled on this clock.
    assign stop_smp = bit_en && (state_q == STOP);

`ifdef RX_PARITY_EN
    logic perr_q;
    logic par_err_q;

    // Latch the parity verdict when the parity bit is sampled; it is judged at the stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else if (bit_en && (state_q == PARITY)) begin
            perr_q <= parity_bad(sin, ^shreg);
        end
    end

    // Parity error is reported only when the frame was otherwise well formed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= stop_smp && sin && perr_q;
        end
    end

    assign par_ok  = !perr_q;
    assign par_err = par_err_q;
`else
    assign par_ok = 1'b1;
`endif

    // A good stop bit with no parity fault delivers the word.
    assign commit = stop_smp && sin && par_ok;

    // Holding register: a commit always wins; otherwise a handshake empties it.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        if (commit) begin
            dout_d  = shreg;
            valid_d = 1'b1;
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output holding register; runs every clock regardless of bit_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // One-clock error pulses and the registered busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ferr_q <= stop_smp && !sin;
            ovr_q  <= commit && valid_q && !dout_ready;
            busy_q <= (state_d != IDLE);
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule
